// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jal steps, with mem_ready/EQ-gated write strobes.
module multicycle_control #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_WAIT  = 1,
    parameter int BNE_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          Instr,
    input  logic                 EQ,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUctrl,
    output logic                 illegal,
    output logic [3:0]           state
);

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic [6:0] op_s;
    logic [2:0] funct3_s;
    logic       mem_rdy_s;
    logic       take_branch_s;
    logic [2:0] alu3_s;
    logic       pcw_s;
    logic       irw_s;
    logic       memw_s;
    logic       regw_s;
    logic       ill_s;
    logic       unused_s;

    function automatic logic [2:0] alu_decode(input logic [6:0] op,
                                              input logic [2:0] f3,
                                              input logic       bit30);
        logic [2:0] res;
        case (f3)
            3'b010:  res = ALU_SLT;
            3'b110:  res = ALU_OR;
            3'b111:  res = ALU_AND;
            3'b000: begin
                if ((op == OP_R) && bit30) begin
                    res = ALU_SUB;
                end else begin
                    res = ALU_ADD;
                end
            end
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    assign op_s          = Instr[6:0];
    assign funct3_s      = Instr[14:12];
    assign mem_rdy_s     = (MEM_WAIT != 32'sd0) ? mem_ready : 1'b1;
    assign take_branch_s = ((BNE_EN != 32'sd0) && (funct3_s == 3'b001)) ? ~EQ : EQ;
    assign unused_s      = ^{Instr[31], Instr[29:15], Instr[11:7]};
    assign state         = state_r;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH:    next_state_s = mem_rdy_s ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op_s)
                    OP_LOAD, OP_STORE: next_state_s = ST_MEMADR;
                    OP_R:              next_state_s = ST_EXECUTER;
                    OP_I:              next_state_s = ST_EXECUTEI;
                    OP_BRANCH:         next_state_s = ST_BRANCH;
                    OP_JAL:            next_state_s = ST_JAL;
                    default:           next_state_s = ST_FETCH;
                endcase
            end
            ST_MEMADR:   next_state_s = op_s[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  next_state_s = mem_rdy_s ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    next_state_s = ST_FETCH;
            ST_MEMWRITE: next_state_s = mem_rdy_s ? ST_FETCH : ST_MEMWRITE;
            ST_EXECUTER: next_state_s = ST_ALUWB;
            ST_EXECUTEI: next_state_s = ST_ALUWB;
            ST_ALUWB:    next_state_s = ST_FETCH;
            ST_BRANCH:   next_state_s = ST_FETCH;
            ST_JAL:      next_state_s = ST_ALUWB;
            default:     next_state_s = ST_FETCH;
        endcase
    end

    // Per-state datapath selects and ungated strobes.
    always_comb begin
        pcw_s     = 1'b0;
        irw_s     = 1'b0;
        memw_s    = 1'b0;
        regw_s    = 1'b0;
        ill_s     = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu3_s    = ALU_ADD;
        case (state_r)
            ST_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_s     = mem_rdy_s;
                irw_s     = mem_rdy_s;
            end
            ST_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op_s)
                    OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL: ill_s = 1'b0;
                    default: ill_s = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            ST_MEMREAD:  AdrSrc = 1'b1;
            ST_MEMWB: begin
                ResultSrc = 2'b01;
                regw_s    = 1'b1;
            end
            ST_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw_s = 1'b1;
            end
            ST_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu3_s  = alu_decode(op_s, funct3_s, Instr[30]);
            end
            ST_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu3_s  = alu_decode(op_s, funct3_s, Instr[30]);
            end
            ST_ALUWB:    regw_s = 1'b1;
            ST_BRANCH: begin
                ALUSrcA = 2'b10;
                alu3_s  = ALU_SUB;
                pcw_s   = take_branch_s;
            end
            ST_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_s   = 1'b1;
            end
            default: begin
                pcw_s = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op_s)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Zero-extend the 3-bit ALU code to the configured width.
    always_comb begin
        ALUctrl      = {ALUCTRL_W{1'b0}};
        ALUctrl[2:0] = alu3_s;
    end

    // Strobes are forced low while reset is held, even though FETCH is active.
    assign PCWrite  = pcw_s  & rst_n;
    assign IRWrite  = irw_s  & rst_n;
    assign MemWrite = memw_s & rst_n;
    assign RegWrite = regw_s & rst_n;
    assign illegal  = ill_s  & rst_n;

endmodule
